// File: rtl/wdt_rib.sv
// wdt_rib: RIB-slave watchdog; a missed kick raises a warning interrupt, a second miss
// (or a bad key) requests a core reset pulse of RST_CYCLES cycles.
module wdt_rib #(
   parameter int          RST_CYCLES = 16,
   parameter logic [31:0] KICK_KEY   = 32'h5A5AA5A5
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        we_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] data_i,
   output logic [31:0] data_o,
   output logic        int_sig_o,
   output logic        rst_req_o
);
   localparam int BW = $clog2(RST_CYCLES + 1);
   localparam logic [BW-1:0] B_LAST = BW'(RST_CYCLES - 1);
   typedef enum logic [1:0] {IDLE, RUN, WARN, BITE} state_t;
   state_t state, state_d;
   logic [2:0] ctrl;
   logic [31:0] load, count, count_d;
   logic [BW-1:0] bcnt, bcnt_d;
   logic warn, bite, warn_set, bite_set, en_clr;
   logic [7:0] a;
   logic wr_ctrl, wr_load, wr_kick, wr_stat, unused_addr;
   assign a = addr_i[7:0];
   assign unused_addr = ^addr_i[31:8];
   assign wr_ctrl = we_i && a == 8'h00 && state != BITE;
   assign wr_load = we_i && a == 8'h04;
   assign wr_kick = we_i && a == 8'h0C;
   assign wr_stat = we_i && a == 8'h10;
   always_comb begin
      state_d  = state;
      count_d  = count;
      bcnt_d   = bcnt;
      warn_set = 1'b0;
      bite_set = 1'b0;
      en_clr   = 1'b0;
      case (state)
         IDLE: if (wr_ctrl && data_i[0] && !ctrl[0]) begin
            count_d = load;
            state_d = RUN;
         end
         BITE: if (bcnt == B_LAST) begin
            en_clr  = 1'b1;
            bcnt_d  = '0;
            state_d = IDLE;
         end else bcnt_d = bcnt + 1'b1;
         default: if (wr_ctrl && !data_i[0]) state_d = IDLE;
         else if (wr_kick && data_i == KICK_KEY) begin
            count_d = load;
            state_d = RUN;
         end else if (wr_kick && ctrl[2]) begin
            state_d  = BITE;
            bite_set = 1'b1;
            bcnt_d   = '0;
         end else if (count == '0) begin
            // second expiry bites only when enabled, otherwise keep warning
            if (state == WARN && ctrl[2]) begin
               state_d  = BITE;
               bite_set = 1'b1;
               bcnt_d   = '0;
            end else begin
               count_d  = load;
               warn_set = state == RUN;
               state_d  = WARN;
            end
         end else count_d = count - 32'd1;
      endcase
   end
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state <= IDLE;
         ctrl  <= '0;
         load  <= 32'hFFFF_FFFF;
         count <= '0;
         bcnt  <= '0;
         warn  <= 1'b0;
         bite  <= 1'b0;
      end else begin
         state <= state_d;
         count <= count_d;
         bcnt  <= bcnt_d;
         if (wr_ctrl) ctrl <= data_i[2:0];
         else if (en_clr) ctrl[0] <= 1'b0;
         if (wr_load) load <= data_i;
         warn <= warn_set | (warn & ~(wr_stat & data_i[0]));
         bite <= bite_set | (bite & ~(wr_stat & data_i[1]));
      end
   end
   assign data_o = a == 8'h00 ? {29'd0, ctrl} :
                   a == 8'h04 ? load :
                   a == 8'h08 ? count :
                   a == 8'h10 ? {30'd0, bite, warn} : 32'd0;
   assign int_sig_o = warn & ctrl[1];
   assign rst_req_o = state == BITE;
endmodule

// File: tb/tb_wdt_rib.sv
// tb_wdt_rib: directed stimulus pushes expected values into a scoreboard queue;
// a negedge monitor pops and compares against the selected DUT output.
module tb_wdt_rib;
   logic clk = 1'b0, rst_ni = 1'b0, we = 1'b0, req = 1'b0;
   logic [31:0] addr = '0, wdata = '0, rdata;
   logic irq, rreq;
   int total = 0, bad = 0;
   typedef struct {int sel; logic [31:0] exp; string name;} item_t;
   item_t q[$];
   localparam logic [31:0] KEY = 32'h5A5AA5A5;

   wdt_rib dut (.clk_i(clk), .rst_ni(rst_ni), .we_i(we), .addr_i(addr), .data_i(wdata),
                .data_o(rdata), .int_sig_o(irq), .rst_req_o(rreq));

   always #5 clk = ~clk;

   always @(negedge clk) if (req) begin
      item_t it;
      logic [31:0] act;
      total++;
      if (q.size() == 0) begin
         bad++;
         $display("FAIL scoreboard_empty");
      end else begin
         it = q.pop_front();
         act = it.sel == 0 ? rdata : it.sel == 1 ? {31'd0, irq} : {31'd0, rreq};
         if (act !== it.exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", it.name, act, it.exp);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [7:0] a, input logic [31:0] d);
      we = 1'b1; addr = {24'd0, a}; wdata = d;
      tick();
      we = 1'b0; wdata = '0;
   endtask

   task automatic chk(input int sel, input logic [7:0] a, input logic [31:0] e, input string n);
      item_t it;
      it.sel = sel; it.exp = e; it.name = n;
      addr = {24'd0, a};
      q.push_back(it);
      req = 1'b1;
      tick();
      req = 1'b0;
   endtask

   initial begin
      repeat (3) tick();
      rst_ni = 1'b1;
      chk(0, 8'h00, 0, "rst_ctrl");
      chk(0, 8'h04, 32'hFFFF_FFFF, "rst_load");
      chk(0, 8'h08, 0, "rst_count");
      chk(0, 8'h10, 0, "rst_status");
      chk(1, 8'h00, 0, "rst_int");
      chk(2, 8'h00, 0, "rst_req");
      chk(0, 8'h0C, 0, "kick_reads0");
      wr(8'h00, 32'hFFFF_FFF8);
      chk(0, 8'h00, 0, "ctrl_upper_bits");
      wr(8'h14, 32'h1234);
      chk(0, 8'h14, 0, "unmapped");
      // warning path: countdown 10..0 then interrupt
      wr(8'h04, 10);
      wr(8'h00, 3);
      for (int k = 0; k <= 10; k++) chk(0, 8'h08, 10 - k, "countdown");
      chk(1, 8'h00, 1, "warn_int");
      chk(0, 8'h08, 9, "warn_count");
      chk(0, 8'h10, 1, "warn_status");
      wr(8'h00, 0);
      chk(0, 8'h08, 7, "frozen_a");
      chk(0, 8'h08, 7, "frozen_b");
      wr(8'h10, 3);
      chk(0, 8'h10, 0, "w1c");
      chk(1, 8'h00, 0, "int_clear");
      // full bite sequence
      wr(8'h00, 7);
      for (int k = 1; k <= 40; k++) chk(2, 8'h00, (k >= 23 && k <= 38) ? 1 : 0, "bite_window");
      chk(0, 8'h10, 3, "bite_status");
      chk(0, 8'h00, 6, "bite_en_clr");
      chk(1, 8'h00, 1, "bite_int");
      wr(8'h10, 3);
      wr(8'h00, 0);
      // periodic good kicks
      wr(8'h00, 7);
      for (int c = 0; c < 100; c++) begin
         if (c % 8 == 7) wr(8'h0C, KEY);
         else if (c % 8 == 0 && c > 0) chk(0, 8'h08, 10, "kick_reload");
         else chk(c % 2 ? 1 : 2, 8'h00, 0, "kick_quiet");
      end
      chk(0, 8'h10, 0, "kick_status");
      wr(8'h00, 0);
      // bad key without bite_en is ignored
      wr(8'h00, 3);
      wr(8'h0C, 32'h12345678);
      chk(2, 8'h00, 0, "badkey_nobite");
      chk(0, 8'h08, 8, "badkey_count");
      chk(0, 8'h10, 0, "badkey_status");
      wr(8'h00, 0);
      // kick racing WARN expiry; then status set beats W1C
      wr(8'h04, 2);
      wr(8'h00, 7);
      repeat (5) tick();
      wr(8'h0C, KEY);
      chk(0, 8'h08, 2, "race_reload");
      chk(0, 8'h10, 1, "race_warn_kept");
      wr(8'h10, 1);
      chk(0, 8'h10, 1, "set_beats_w1c");
      chk(2, 8'h00, 0, "race_no_bite");
      wr(8'h00, 0);
      wr(8'h10, 1);
      chk(0, 8'h10, 0, "race_w1c");
      // LOAD=0: expiry one cycle after entering RUN
      wr(8'h04, 0);
      wr(8'h00, 3);
      chk(1, 8'h00, 0, "load0_run");
      chk(1, 8'h00, 1, "load0_warn");
      wr(8'h00, 0);
      wr(8'h10, 1);
      // bad key with bite_en, then reset mid-bite
      wr(8'h04, 10);
      wr(8'h00, 7);
      wr(8'h0C, 32'h12345678);
      chk(2, 8'h00, 1, "badkey_bite");
      chk(0, 8'h10, 2, "badkey_bite_status");
      wr(8'h00, 0);
      chk(0, 8'h00, 7, "ctrl_locked_in_bite");
      rst_ni = 1'b0;
      tick();
      rst_ni = 1'b1;
      chk(2, 8'h00, 0, "midbite_rst_req");
      chk(0, 8'h00, 0, "midbite_ctrl");
      chk(0, 8'h04, 32'hFFFF_FFFF, "midbite_load");
      chk(0, 8'h08, 0, "midbite_count");
      chk(0, 8'h10, 0, "midbite_status");
      tick();
      if (q.size() != 0) begin
         bad++;
         $display("FAIL scoreboard_leftover: got %0d expected 0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
